// File: rtl/tx_byte_queue_pkg.sv
// Shared defaults and launch-FSM encoding for the UART transmit byte queue.
package tx_byte_queue_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_BUSY_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } tx_state_e;

endpackage

// File: rtl/tx_byte_queue_if.sv
// Byte-in / transmitter-out bundle of the transmit queue, plus occupancy status.
interface tx_byte_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              tx_busy;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;

    modport master (
        output in_data, in_valid, tx_busy,
        input  tx_data, tx_start, count, empty, full, overflow
    );

    modport slave (
        input  in_data, in_valid, tx_busy,
        output tx_data, tx_start, count, empty, full, overflow
    );
endinterface

// File: rtl/tx_byte_queue_byte_fifo.sv
// Circular byte buffer with explicit occupancy count, registered flags and sticky overflow.
module tx_byte_queue_byte_fifo
    import tx_byte_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              w_push_ok;
    logic [ADDR_W:0]   w_count_nxt;

    // A full queue still takes a byte when a pop frees a slot on the same edge.
    assign w_push_ok = i_push && (!r_full || i_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, i_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == FULL_CNT);
            if (i_push && !w_push_ok)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;
endmodule

// File: rtl/tx_byte_queue.sv
// Queues transformed bytes and launches them one per UART frame while the
// transmitter is idle, with a timeout in case tx_busy never answers a start.
module tx_byte_queue
    import tx_byte_queue_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input logic           i_clk,
    input logic           i_rst,
    tx_byte_queue_if.slave bus
);
    localparam int TMR_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] w_fifo_rd;
    logic              w_pop;
    logic              w_start;

    tx_byte_queue_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (bus.in_valid),
        .i_push_data (bus.in_data),
        .i_pop       (w_pop),
        .o_rd_data   (w_fifo_rd),
        .o_count     (bus.count),
        .o_empty     (bus.empty),
        .o_full      (bus.full),
        .o_overflow  (bus.overflow)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pop       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.empty && !bus.tx_busy)
                    w_state_nxt = LOAD;
            end
            LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = START;
            end
            START: begin
                w_start     = 1'b1;
                w_timer_nxt = '0;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never acknowledges must not wedge the queue.
                if (bus.tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                    if (w_timer_nxt == TMR_LAST)
                        w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            if (w_pop)
                r_tx_data <= w_fifo_rd;
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_start = w_start;
endmodule

// File: doc/tx_byte_queue.md
Name: tx_byte_queue

Overview:
- Buffers processed bytes from the cipher/hash stage and paces them into the UART Transmitter, one byte per frame.
- Sits between the byte-transform stage (fed by the Receiver) and the Transmitter.
- Absorbs bursts that arrive faster than the line rate.
- Issues a one-cycle start pulse only when the Transmitter is idle.

Parameters:
- DATA_W, 8, byte width.
- DEPTH, 16, queue entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- BUSY_TIMEOUT, 64, cycles to wait for tx_busy to rise after tx_start before giving up.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  byte from the transform stage.
- in_valid  in  1  one-cycle strobe; in_data is valid this cycle.
- tx_busy  in  1  high while the Transmitter is shifting a frame.
- tx_data  out  DATA_W  byte presented to the Transmitter.
- tx_start  out  1  one-cycle pulse; the Transmitter latches tx_data on it.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a byte was dropped.

Behaviour:
- Reset (async, active-high): rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0, tx_data=0, tx_start=0, FSM=IDLE. Applying reset mid-frame abandons the frame; no pulse is issued after reset releases.
- Storage: circular buffer, DEPTH x DATA_W. Pointers are ADDR_W bits wide and wrap from DEPTH-1 to 0. count is kept explicitly.
- Push: accepted on in_valid when not full, or when full and a pop occurs in the same cycle.
  - Data is written at wr_ptr; wr_ptr increments.
  - A rejected push sets overflow; overflow clears only on reset.
- Pop: occurs only in state LOAD.
  - tx_data <= mem[rd_ptr]; rd_ptr increments.
- count update: push only → +1; pop only → -1; both → unchanged.
- Flags full and empty are registered views of count, updated in the same edge as count.
- FSM states:
  - IDLE: if !empty and !tx_busy → LOAD. Otherwise stay.
  - LOAD: pop one byte into tx_data → START.
  - START: tx_start=1 for exactly this cycle; timer cleared → WAIT_BUSY.
  - WAIT_BUSY: if tx_busy → WAIT_DONE. Otherwise the timer increments; when timer reaches BUSY_TIMEOUT-1 → IDLE (byte is considered sent).
  - WAIT_DONE: when !tx_busy → IDLE.
- tx_data holds its value from LOAD until the next LOAD.
- Latency: from a push into an empty queue with the Transmitter idle, tx_start asserts 3 cycles later (IDLE sees !empty, then LOAD, then START).
- Back-to-back bytes: at least 2 idle cycles between tx_busy falling and the next tx_start.
- A push in the same cycle as LOAD is legal at any occupancy, including full.
- in_valid with empty and FSM idle is not forwarded combinationally; it always goes through the buffer.
- A tx_busy that is already high in IDLE blocks launch until it falls.

Decomposition:
- Shared package holds:
  - DATA_W default.
  - FSM state encoding: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE (3 bits).
  - BUSY_TIMEOUT default.
- One sub-module is natural: byte_fifo, covering storage, pointers, count, flags and overflow, with a push/pop interface.
- tx_byte_queue keeps the launch FSM and the timeout counter.

Test Plan:
- Reset mid-WAIT_DONE with 3 bytes queued → count=0, empty=1, tx_start stays 0 for 20 cycles after release.
- Single push 8'hA5, tx_busy model rises 2 cycles after tx_start and holds 100 cycles → tx_start pulses 3 cycles after the push with tx_data=8'hA5; no second pulse; count returns to 0.
- Burst of 16 pushes (8'h00..8'h0F) on consecutive cycles with tx_busy held high → full=1, count=16, overflow=0. A 17th push sets overflow=1; after tx_busy drops, output order is 00..0F, and the 17th byte never appears.
- Full queue, push 8'h77 in the same cycle as LOAD → push accepted, count stays 16, overflow stays 0, 8'h77 is emitted last.
- tx_busy never rises after tx_start → FSM returns to IDLE BUSY_TIMEOUT cycles after the pulse, and the next queued byte launches.
- Wrap-around: 40 bytes in total pushed at one byte per Transmitter frame → pointers wrap twice; all 40 bytes emerge in order; empty=1 at the end.
